// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_sequencer_pkg: shared opcodes, FSM states, IR field positions and control-word decode
// Contents: state_t (IDLE..DONE), OP_* ALU opcodes, IR field bit positions,
//           ctrl_t control word, ctrl_decode() Moore decode of state + IR.
package alu_op_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_DONE
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_SHR  = 5'd5;
    localparam logic [4:0] OP_SHRA = 5'd6;
    localparam logic [4:0] OP_SHL  = 5'd7;
    localparam logic [4:0] OP_ROR  = 5'd8;
    localparam logic [4:0] OP_ROL  = 5'd9;
    localparam logic [4:0] OP_AND  = 5'd10;
    localparam logic [4:0] OP_OR   = 5'd11;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    typedef struct packed {
        logic [4:0] alu_opcode;
        logic       inc_pc;
        logic       pc_out;
        logic       pc_in;
        logic [3:0] rf_rd_sel;
        logic       rf_out;
        logic       y_in;
        logic       z_in;
        logic       zlo_out;
        logic [3:0] rf_wr_sel;
        logic       rf_wr_en;
        logic       busy;
        logic       done;
        logic       illegal;
    } ctrl_t;

    // Bus drivers are split across states so only one of pc_out/rf_out/zlo_out is ever high.
    function automatic ctrl_t ctrl_decode(input state_t s, input logic [31:0] ir, input logic legal);
        ctrl_t c;
        c.alu_opcode = (s == S_T3) ? ir[OP_MSB:OP_LSB] : 5'd0;
        c.inc_pc     = (s == S_T0);
        c.pc_out     = (s == S_T0);
        c.pc_in      = (s == S_T1);
        c.rf_rd_sel  = (s == S_T2) ? ir[RB_MSB:RB_LSB] : (s == S_T3) ? ir[RC_MSB:RC_LSB] : 4'd0;
        c.rf_out     = (s == S_T2) || (s == S_T3);
        c.y_in       = (s == S_T2);
        c.z_in       = (s == S_T0) || (s == S_T3);
        c.zlo_out    = (s == S_T1) || (s == S_T4);
        c.rf_wr_sel  = ir[RA_MSB:RA_LSB];
        c.rf_wr_en   = (s == S_T4) && legal;
        c.busy       = (s != S_IDLE);
        c.done       = (s == S_DONE);
        c.illegal    = (s == S_DONE) && !legal;
        return c;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_decode.sv
// alu_op_decode: flags whether an opcode is one the ALU implements
// Ports: opcode (in, 5) -> legal (out, 1), high for ADD..OR.
module alu_op_decode
    import alu_op_sequencer_pkg::*;
(
    input  logic [4:0] opcode,
    output logic       legal
);

    assign legal = (opcode >= OP_ADD) && (opcode <= OP_OR);

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle control sequencer for R-format ALU instructions
// Ports: clock, clear (async active-low), start, ir[31:0] in;
//        alu_opcode, inc_pc, pc_out, pc_in, rf_rd_sel, rf_out, y_in, z_in, zlo_out,
//        rf_wr_sel, rf_wr_en, busy, done, illegal out (all registered).
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] ir,
    output logic [4:0]  alu_opcode,
    output logic        inc_pc,
    output logic        pc_out,
    output logic        pc_in,
    output logic [3:0]  rf_rd_sel,
    output logic        rf_out,
    output logic        y_in,
    output logic        z_in,
    output logic        zlo_out,
    output logic [3:0]  rf_wr_sel,
    output logic        rf_wr_en,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    state_t      state, state_nxt;
    logic [31:0] ir_q, ir_nxt;
    logic        legal_q, legal_nxt;
    ctrl_t       ctrl;

    alu_op_decode u_decode (
        .opcode(ir_nxt[OP_MSB:OP_LSB]),
        .legal (legal_nxt)
    );

    always_comb begin
        ir_nxt = (state == S_IDLE && start) ? ir : ir_q;
        case (state)
            S_IDLE:  state_nxt = start ? S_T0 : S_IDLE;
            S_T0:    state_nxt = S_T1;
            S_T1:    state_nxt = legal_q ? S_T2 : S_DONE;
            S_T2:    state_nxt = S_T3;
            S_T3:    state_nxt = S_T4;
            S_T4:    state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state   <= S_IDLE;
            ir_q    <= '0;
            legal_q <= 1'b0;
            ctrl    <= '0;
        end else begin
            state   <= state_nxt;
            ir_q    <= ir_nxt;
            legal_q <= legal_nxt;
            ctrl    <= ctrl_decode(state_nxt, ir_nxt, legal_nxt);
        end
    end

    assign alu_opcode = ctrl.alu_opcode;
    assign inc_pc     = ctrl.inc_pc;
    assign pc_out     = ctrl.pc_out;
    assign pc_in      = ctrl.pc_in;
    assign rf_rd_sel  = ctrl.rf_rd_sel;
    assign rf_out     = ctrl.rf_out;
    assign y_in       = ctrl.y_in;
    assign z_in       = ctrl.z_in;
    assign zlo_out    = ctrl.zlo_out;
    assign rf_wr_sel  = ctrl.rf_wr_sel;
    assign rf_wr_en   = ctrl.rf_wr_en;
    assign busy       = ctrl.busy;
    assign done       = ctrl.done;
    assign illegal    = ctrl.illegal;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: self-checking bench with a bus/datapath environment and architectural reference model
module tb_alu_op_sequencer;

    logic        clock = 1'b0;
    logic        clear, start;
    logic [31:0] ir;
    logic [4:0]  alu_opcode;
    logic        inc_pc, pc_out, pc_in, rf_out, y_in, z_in, zlo_out, rf_wr_en, busy, done, illegal;
    logic [3:0]  rf_rd_sel, rf_wr_sel;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    alu_op_sequencer dut (
        .clock(clock), .clear(clear), .start(start), .ir(ir),
        .alu_opcode(alu_opcode), .inc_pc(inc_pc), .pc_out(pc_out), .pc_in(pc_in),
        .rf_rd_sel(rf_rd_sel), .rf_out(rf_out), .y_in(y_in), .z_in(z_in), .zlo_out(zlo_out),
        .rf_wr_sel(rf_wr_sel), .rf_wr_en(rf_wr_en), .busy(busy), .done(done), .illegal(illegal)
    );

    logic [23:0] outs;
    assign outs = {alu_opcode, inc_pc, pc_out, pc_in, rf_rd_sel, rf_out, y_in, z_in, zlo_out,
                   rf_wr_sel, rf_wr_en, busy, done, illegal};

    function automatic logic [23:0] mk(input logic [4:0] opc, input logic inc, pco, pci,
                                       input logic [3:0] rd, input logic rfo, yi, zi, zl,
                                       input logic [3:0] ws, input logic we, bz, dn, il);
        return {opc, inc, pco, pci, rd, rfo, yi, zi, zl, ws, we, bz, dn, il};
    endfunction

    function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, b);
        logic [63:0] w;
        w = {a, a};
        case (op)
            5'd3:    return a + b;
            5'd4:    return a - b;
            5'd5:    return a >> b[4:0];
            5'd6:    return $signed(a) >>> b[4:0];
            5'd7:    return a << b[4:0];
            5'd8:    begin w = w >> b[4:0]; return w[31:0]; end
            5'd9:    begin w = w << b[4:0]; return w[63:32]; end
            5'd10:   return a & b;
            5'd11:   return a | b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit is_legal(input logic [4:0] op);
        return op >= 5'd3 && op <= 5'd11;
    endfunction

    // Datapath environment driven by the sequencer's strobes: PC, Y, Z-LO, register file, one bus.
    logic [31:0] rf [16];
    logic [31:0] pc, y, zlo, bus;
    logic        pl_en = 1'b0;
    logic [4:0]  pl_idx = 5'd0;
    logic [31:0] pl_val = 32'd0;

    assign bus = pc_out ? pc : rf_out ? rf[rf_rd_sel] : zlo_out ? zlo : 32'd0;

    always @(posedge clock) begin
        if (pl_en && pl_idx == 5'd16) pc <= pl_val;
        else if (pl_en) rf[pl_idx[3:0]] <= pl_val;
        if (pc_in) pc <= bus;
        if (y_in) y <= bus;
        if (z_in) zlo <= inc_pc ? bus + 32'd1 : alu_f(alu_opcode, y, bus);
        if (rf_wr_en) rf[rf_wr_sel] <= bus;
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    always @(negedge clock) begin
        n_chk++;
        if ((int'(pc_out) + int'(rf_out) + int'(zlo_out)) > 1 || (illegal && !done) || (done && !busy)) begin
            n_fail++;
            $display("FAIL bus_flags: pc_out=%b rf_out=%b zlo_out=%b busy=%b done=%b illegal=%b, expected one bus driver and flags only in DONE",
                     pc_out, rf_out, zlo_out, busy, done, illegal);
        end
    end

    task automatic set_reg(input int k, input logic [31:0] v);
        pl_idx = 5'(k);
        pl_val = v;
        pl_en  = 1'b1;
        @(negedge clock);
        pl_en  = 1'b0;
    endtask

    // Architectural reference: one instruction updates Ra from Rb op Rc (legal only) and bumps PC.
    task automatic run_instr(input string nm, input logic [31:0] i);
        logic [31:0] exp_rf [16];
        logic [31:0] exp_pc;
        int lat;
        bit lg;
        exp_rf = rf;
        exp_pc = pc + 32'd1;
        lg = is_legal(i[31:27]);
        if (lg) exp_rf[i[26:23]] = alu_f(i[31:27], rf[i[22:19]], rf[i[18:15]]);
        start = 1'b1;
        ir = i;
        @(negedge clock);
        start = 1'b0;
        ir = $urandom;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), lg ? 64'd6 : 64'd3);
        chk({nm, "_illegal"}, 64'(illegal), 64'(!lg));
        @(negedge clock);
        chk({nm, "_pc"}, pc, exp_pc);
        for (int k = 0; k < 16; k++) chk($sformatf("%s_r%0d", nm, k), rf[k], exp_rf[k]);
    endtask

    logic [23:0] ev [8];

    task automatic seq_chk(input string nm, input logic [31:0] i, input int n);
        start = 1'b1;
        ir = i;
        @(negedge clock);
        start = 1'b0;
        ir = ~i;
        for (int c = 0; c < n; c++) begin
            chk($sformatf("%s_c%0d", nm, c + 1), outs, ev[c]);
            @(negedge clock);
        end
    endtask

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] res;
    } vec_t;

    vec_t        tbl [12];
    logic [31:0] snap [16];
    logic [31:0] pc0;
    logic [31:0] acc_q [$];
    bit          dexp [48];
    int          next_acc;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{5'd3,  32'd5,          32'd7,          32'd12};
        tbl[1]  = '{5'd4,  32'd5,          32'd7,          32'hFFFF_FFFE};
        tbl[2]  = '{5'd5,  32'h8000_0000,  32'd4,          32'h0800_0000};
        tbl[3]  = '{5'd6,  32'h8000_0000,  32'd4,          32'hF800_0000};
        tbl[4]  = '{5'd7,  32'd1,          32'd31,         32'h8000_0000};
        tbl[5]  = '{5'd8,  32'd1,          32'd1,          32'h8000_0000};
        tbl[6]  = '{5'd9,  32'h8000_0000,  32'd1,          32'h0000_0001};
        tbl[7]  = '{5'd10, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000};
        tbl[8]  = '{5'd11, 32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF};
        tbl[9]  = '{5'd0,  32'd5,          32'd7,          32'hDEAD_BEEF};
        tbl[10] = '{5'd12, 32'd5,          32'd7,          32'hDEAD_BEEF};
        tbl[11] = '{5'd31, 32'd5,          32'd7,          32'hDEAD_BEEF};

        clear = 1'b0;
        start = 1'b0;
        ir = 32'd0;
        @(negedge clock);
        for (int k = 0; k < 17; k++) set_reg(k, k == 16 ? 32'h100 : 32'h1000 + 32'(k));
        for (int k = 0; k < 3; k++) begin
            chk("reset_outs", outs, 0);
            chk("reset_busy", busy, 0);
            @(negedge clock);
        end
        clear = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("idle_outs", outs, 0);
            @(negedge clock);
        end

        // add R1,R2,R3 cycle by cycle
        ev[0] = mk(5'd0, 1, 1, 0, 4'd0, 0, 0, 1, 0, 4'd1, 0, 1, 0, 0);
        ev[1] = mk(5'd0, 0, 0, 1, 4'd0, 0, 0, 0, 1, 4'd1, 0, 1, 0, 0);
        ev[2] = mk(5'd0, 0, 0, 0, 4'd2, 1, 1, 0, 0, 4'd1, 0, 1, 0, 0);
        ev[3] = mk(5'd3, 0, 0, 0, 4'd3, 1, 0, 1, 0, 4'd1, 0, 1, 0, 0);
        ev[4] = mk(5'd0, 0, 0, 0, 4'd0, 0, 0, 0, 1, 4'd1, 1, 1, 0, 0);
        ev[5] = mk(5'd0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 4'd1, 0, 1, 1, 0);
        ev[6] = mk(5'd0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 4'd1, 0, 0, 0, 0);
        seq_chk("add_seq", 32'h1891_8000, 7);

        // opcode 31: only fetch phases, then DONE with illegal
        snap = rf;
        pc0 = pc;
        ev[0] = mk(5'd0, 1, 1, 0, 4'd0, 0, 0, 1, 0, 4'd0, 0, 1, 0, 0);
        ev[1] = mk(5'd0, 0, 0, 1, 4'd0, 0, 0, 0, 1, 4'd0, 0, 1, 0, 0);
        ev[2] = mk(5'd0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 1, 1, 1);
        ev[3] = mk(5'd0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0);
        seq_chk("ill_seq", 32'hF800_0000, 4);
        chk("ill_pc", pc, pc0 + 32'd1);
        for (int k = 0; k < 16; k++) chk($sformatf("ill_r%0d", k), rf[k], snap[k]);

        // or R4,R5,R6
        set_reg(5, 32'h0000_00F0);
        set_reg(6, 32'h0000_000F);
        run_instr("or_r4", 32'h5A2B_0000);
        chk("or_r4_value", rf[4], 32'h0000_00FF);

        for (int k = 0; k < 12; k++) begin
            set_reg(1, 32'hDEAD_BEEF);
            set_reg(2, tbl[k].b);
            set_reg(3, tbl[k].c);
            run_instr($sformatf("tbl%0d", k), {tbl[k].op, 4'd1, 4'd2, 4'd3, 15'd0});
            chk($sformatf("tbl%0d_result", k), rf[1], tbl[k].res);
        end

        // clear pulsed in T3 of an add
        set_reg(1, 32'h5555_5555);
        set_reg(2, 32'd10);
        set_reg(3, 32'd20);
        start = 1'b1;
        ir = 32'h1891_8000;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        chk("abort_t3_opcode", alu_opcode, 5'd3);
        #2 clear = 1'b0;
        #1 chk("abort_async_outs", outs, 0);
        @(negedge clock);
        clear = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("abort_idle_outs", outs, 0);
            @(negedge clock);
        end
        chk("abort_r1_kept", rf[1], 32'h5555_5555);
        run_instr("post_abort", 32'h1891_8000);
        chk("post_abort_r1", rf[1], 32'd30);

        // start held high, ir changing every cycle
        snap = rf;
        pc0 = pc;
        next_acc = 0;
        for (int c = 0; c < 48; c++) dexp[c] = 1'b0;
        for (int c = 0; c < 44; c++) begin
            chk($sformatf("b2b_done_c%0d", c), done, dexp[c]);
            start = (c < 30);
            ir = $urandom;
            if (start && c == next_acc) begin
                acc_q.push_back(ir);
                dexp[c + (is_legal(ir[31:27]) ? 6 : 3)] = 1'b1;
                next_acc = c + (is_legal(ir[31:27]) ? 7 : 4);
            end
            @(negedge clock);
        end
        foreach (acc_q[n])
            if (is_legal(acc_q[n][31:27]))
                snap[acc_q[n][26:23]] = alu_f(acc_q[n][31:27], snap[acc_q[n][22:19]], snap[acc_q[n][18:15]]);
        chk("b2b_pc", pc, pc0 + 32'(acc_q.size()));
        for (int k = 0; k < 16; k++) chk($sformatf("b2b_r%0d", k), rf[k], snap[k]);

        for (int t = 0; t < 30; t++) begin
            logic [31:0] ri;
            ri = $urandom;
            ri[31:27] = (t % 4 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(3, 11));
            set_reg(int'(ri[22:19]), $urandom);
            set_reg(int'(ri[18:15]), $urandom);
            run_instr($sformatf("rnd%0d", t), ri);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
